// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit registered ALU and its result buffer.
// The op-select encoding is kept here so every block that drives or models the ALU agrees on it.
package alu_pkg;

   localparam int DATA_W  = 8;
   localparam int ALU_LAT = 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_MAX = 2'b01,
      OP_SUB = 2'b10,
      OP_MIN = 2'b11
   } alu_op_e;

endpackage

// File: rtl/alu_lat_pipe.sv
// Latency-matched valid pipe: mirrors the ALU's fixed latency so the tail bit marks a valid result.
// Also reports how many issued operations are still travelling through the ALU.
module alu_lat_pipe
   import alu_pkg::*;
#(
   parameter int LAT   = alu_pkg::ALU_LAT,
   parameter int INF_W = $clog2(LAT + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_issue,
   output logic             o_tail,
   output logic [INF_W-1:0] o_inflight
);

   logic [LAT-1:0] pipe_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= i_issue;
         for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign o_tail = pipe_q[LAT-1];

   always_comb begin
      o_inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         o_inflight = o_inflight + INF_W'(pipe_q[i]);
      end
   end

endmodule

// File: rtl/alu_result_buffer.sv
// Captures each ALU result into a small FIFO and presents it to the consumer.
// A credit output keeps a well-behaved issuer from ever overrunning the FIFO.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter  int DATA_W  = alu_pkg::DATA_W,
   parameter  int DEPTH   = 4,
   parameter  int ALU_LAT = alu_pkg::ALU_LAT,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_issue,
   input  logic [DATA_W-1:0] i_result,
   input  logic              i_ready,
   input  logic              i_clr_ovf,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_issue_ok,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int INF_W = $clog2(ALU_LAT + 1);
   localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              ovf_q;

   logic              push;
   logic              pop;
   logic              do_write;
   logic              ovf_set;
   logic [INF_W-1:0]  inflight;
   logic [SUM_W-1:0]  credit_sum;

   alu_lat_pipe #(
      .LAT   (ALU_LAT),
      .INF_W (INF_W)
   ) u_lat_pipe (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_issue    (i_issue),
      .o_tail     (push),
      .o_inflight (inflight)
   );

   // Handshake: a result transfers on every rising edge where o_valid and i_ready are both high;
   // o_valid never depends on i_ready, and o_data holds while o_valid is high and i_ready is low.
   assign pop      = o_valid & i_ready;
   assign do_write = push & (~o_full | pop);
   assign ovf_set  = push & o_full & ~pop;

   always_ff @(posedge i_clk) begin
      if (do_write) begin
         mem[wr_ptr_q] <= i_result;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (do_write) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_write, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         // A drop in the same cycle as a clear must stay visible.
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (i_clr_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign o_count = count_q;
   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_valid = ~o_empty;
   assign o_data  = o_valid ? mem[rd_ptr_q] : '0;
   assign o_ovf   = ovf_q;

   // Results still inside the ALU already own a FIFO slot; a same-cycle pop is deliberately ignored.
   assign credit_sum = SUM_W'(count_q) + SUM_W'(inflight);
   assign o_issue_ok = (credit_sum < SUM_W'(DEPTH));

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: a registered ALU model feeds the DUT, a queue-level reference
// model is compared every cycle, and directed scenarios pin the model with literal values.
module tb_alu_result_buffer;
   import alu_pkg::*;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int LAT   = 2;

   typedef struct {
      int           due;
      logic [W-1:0] val;
   } pend_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         issue = 1'b0;
   logic         ready = 1'b0;
   logic         clr_ovf = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic [1:0]   op_sel = '0;

   logic [W-1:0] a_q, b_q, alu_res;
   logic [1:0]   sel_q;

   logic [W-1:0] o_data;
   logic         o_valid, o_issue_ok, o_full, o_empty, o_ovf;
   logic [2:0]   o_count;

   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   logic         m_ovf = 1'b0;
   pend_t        pend_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] out_log[$];
   logic [W-1:0] t5_exp[$];

   logic [W-1:0] t2_a[4]   = '{8'h10, 8'h05, 8'h05, 8'hFF};
   logic [W-1:0] t2_b[4]   = '{8'h01, 8'h09, 8'h09, 8'h01};
   logic [1:0]   t2_s[4]   = '{OP_SUB, OP_MAX, OP_MIN, OP_ADD};
   logic [W-1:0] t2_exp[4] = '{8'h0F, 8'h09, 8'h05, 8'h00};
   logic [W-1:0] t4_a[4]   = '{8'h01, 8'h02, 8'h08, 8'h05};
   logic [W-1:0] t4_b[4]   = '{8'h01, 8'h01, 8'h04, 8'h01};
   logic [1:0]   t4_s[4]   = '{OP_ADD, OP_ADD, OP_SUB, OP_MAX};
   logic [W-1:0] t4_exp[5] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h77};

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   alu_result_buffer dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_issue    (issue),
      .i_result   (alu_res),
      .i_ready    (ready),
      .i_clr_ovf  (clr_ovf),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_issue_ok (o_issue_ok),
      .o_count    (o_count),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_ovf      (o_ovf)
   );

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] s);
      case (s)
         OP_ADD:  return a + b;
         OP_MAX:  return (a > b) ? a : b;
         OP_SUB:  return a - b;
         default: return (a < b) ? a : b;
      endcase
   endfunction

   // Registered ALU: operand register, then result register.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         alu_res <= '0;
      end else begin
         a_q     <= op_a;
         b_q     <= op_b;
         sel_q   <= op_sel;
         alu_res <= alu_f(a_q, b_q, sel_q);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   always @(posedge clk) begin : model
      logic  full_before, popped, dropped;
      pend_t p;
      if (!rst_n) begin
         pend_q.delete();
         exp_q.delete();
         m_ovf = 1'b0;
      end else begin
         full_before = (exp_q.size() == DEPTH);
         popped      = (exp_q.size() > 0) && ready;
         dropped     = 1'b0;
         if (popped) void'(exp_q.pop_front());
         if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            p = pend_q.pop_front();
            if (!full_before || popped) exp_q.push_back(p.val);
            else dropped = 1'b1;
         end
         if (dropped) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         if (issue) pend_q.push_back('{cyc + LAT, alu_f(op_a, op_b, op_sel)});
      end
      cyc++;
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid", o_valid, 1'b0);
         chk("rst_data", o_data, 8'h00);
         chk("rst_count", o_count, 3'd0);
         chk("rst_empty", o_empty, 1'b1);
         chk("rst_full", o_full, 1'b0);
         chk("rst_issue_ok", o_issue_ok, 1'b1);
         chk("rst_ovf", o_ovf, 1'b0);
      end else begin
         chk("valid", o_valid, exp_q.size() > 0);
         chk("data", o_data, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
         chk("count", o_count, exp_q.size());
         chk("full", o_full, exp_q.size() == DEPTH);
         chk("empty", o_empty, exp_q.size() == 0);
         chk("issue_ok", o_issue_ok, (exp_q.size() + pend_q.size()) < DEPTH);
         chk("ovf", o_ovf, m_ovf);
         if (o_valid && ready) out_log.push_back(o_data);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
      issue  = 1'b1;
      op_a   = a;
      op_b   = b;
      op_sel = s;
   endtask

   task automatic wait_log(input string name, input int n, input int budget);
      int k = 0;
      while (out_log.size() < n && k < budget) begin
         step();
         k++;
      end
      chk(name, out_log.size() >= n, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int n_iss;
      int k;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      step();

      // Single ADD, consumer always ready.
      ready = 1'b1;
      set_op(8'h12, 8'h34, OP_ADD);
      step();
      issue = 1'b0;
      step();
      chk("t1_count_c2", o_count, 3'd0);
      step();
      chk("t1_valid_c3", o_valid, 1'b1);
      chk("t1_data_c3", o_data, 8'h46);
      chk("t1_count_c3", o_count, 3'd1);
      step();
      chk("t1_valid_c4", o_valid, 1'b0);
      chk("t1_count_c4", o_count, 3'd0);

      // Fill under backpressure.
      ready = 1'b0;
      out_log.delete();
      for (int i = 0; i < 4; i++) begin
         set_op(t2_a[i], t2_b[i], t2_s[i]);
         step();
      end
      issue = 1'b0;
      chk("t2_issue_ok_c4", o_issue_ok, 1'b0);
      step();
      step();
      chk("t2_full_c6", o_full, 1'b1);
      chk("t2_ovf_c6", o_ovf, 1'b0);
      chk("t2_issue_ok_c6", o_issue_ok, 1'b0);

      // Forced issue into a full FIFO.
      set_op(8'hAA, 8'h01, OP_ADD);
      step();
      issue = 1'b0;
      step();
      step();
      chk("t3_ovf", o_ovf, 1'b1);
      chk("t3_count", o_count, 3'd4);
      chk("t3_head", o_data, 8'h0F);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("t3_ovf_clr", o_ovf, 1'b0);
      ready = 1'b1;
      wait_log("t2_drain_timeout", 4, 20);
      for (int i = 0; i < 4 && i < out_log.size(); i++) chk("t2_order", out_log[i], t2_exp[i]);
      ready = 1'b0;

      // Push and pop in the same cycle while full.
      out_log.delete();
      for (int i = 0; i < 4; i++) begin
         set_op(t4_a[i], t4_b[i], t4_s[i]);
         step();
      end
      issue = 1'b0;
      step();
      step();
      chk("t4_full", o_full, 1'b1);
      set_op(8'h77, 8'h99, OP_MIN);
      step();
      issue = 1'b0;
      step();
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("t4_count", o_count, 3'd4);
      chk("t4_ovf", o_ovf, 1'b0);
      chk("t4_head", o_data, 8'h03);
      ready = 1'b1;
      wait_log("t4_drain_timeout", 5, 20);
      for (int i = 0; i < 5 && i < out_log.size(); i++) chk("t4_order", out_log[i], t4_exp[i]);
      ready = 1'b0;
      step();

      // Stream across pointer wrap with toggling ready, issuer honours credit.
      out_log.delete();
      t5_exp.delete();
      n_iss = 0;
      k = 0;
      while ((n_iss < 12 || out_log.size() < 12) && k < 300) begin
         ready = (k % 2 == 0);
         if (n_iss < 12 && o_issue_ok) begin
            set_op(8'(n_iss * 37 + 3), 8'(n_iss * 11), 2'(n_iss));
            t5_exp.push_back(alu_f(8'(n_iss * 37 + 3), 8'(n_iss * 11), 2'(n_iss)));
            n_iss++;
         end else begin
            issue = 1'b0;
         end
         step();
         k++;
      end
      issue = 1'b0;
      ready = 1'b0;
      chk("t5_count_out", out_log.size(), 12);
      for (int i = 0; i < 12 && i < out_log.size(); i++) chk("t5_order", out_log[i], t5_exp[i]);
      chk("t5_ovf", o_ovf, 1'b0);
      step();

      // Reset while two results are in flight.
      out_log.delete();
      ready = 1'b1;
      set_op(8'h01, 8'h02, OP_ADD);
      step();
      set_op(8'h03, 8'h04, OP_ADD);
      step();
      issue = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", o_valid, 1'b0);
      chk("t6_rst_count", o_count, 3'd0);
      chk("t6_rst_issue_ok", o_issue_ok, 1'b1);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t6_valid", o_valid, 1'b0);
         chk("t6_count", o_count, 3'd0);
         chk("t6_issue_ok", o_issue_ok, 1'b1);
      end
      chk("t6_no_output", out_log.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 8-bit registered ALU.
- The ALU has a fixed 2-cycle latency: input register, then output register. It has no valid signal.
- This block tracks issued operations with a latency-matched valid pipe and captures each ALU result into a small FIFO.
- It presents results to the consumer with a valid/ready handshake and gives a credit signal back to the issuer so no result is lost.

Parameters:
- DATA_W, 8, result width; must equal the ALU width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ALU_LAT, 2, cycles from i_issue (operands on ALU i_a/i_b/i_sel) to a valid ALU o_result.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_reset, input, 1: asynchronous, active-low reset.
- i_issue, input, 1: the issuer presents a new operation to the ALU this cycle.
- i_result, input, DATA_W: the ALU o_result.
- i_ready, input, 1: the consumer accepts o_data this cycle.
- i_clr_ovf, input, 1: synchronous clear of o_ovf.
- o_data, output, DATA_W: head-of-FIFO result.
- o_valid, output, 1: o_data is valid.
- o_issue_ok, output, 1: credit; the issuer may assert i_issue this cycle.
- o_count, output, $clog2(DEPTH+1): entries stored.
- o_full, output, 1: o_count == DEPTH.
- o_empty, output, 1: o_count == 0.
- o_ovf, output, 1: sticky; a result was dropped.

Behaviour:
- Reset: i_reset is asynchronous, active-low; clock is i_clk.
  - While low, the valid pipe, pointers and count are cleared, and o_ovf is 0.
  - Output values during reset: o_valid=0, o_data=0, o_count=0, o_empty=1, o_full=0, o_issue_ok=1.
  - Reset mid-operation discards in-flight and stored results. The ALU is reset by the same signal, so the two stay consistent.
- Valid pipe:
  - ALU_LAT-stage shift register; stage0 <= i_issue each cycle.
  - The tail stage high means i_result is valid this cycle, which produces a push.
- Push/pop:
  - push = tail.
  - pop = o_valid & i_ready.
  - The write happens at the clock edge: mem[wr_ptr] <= i_result.
- FIFO:
  - Registered storage, no bypass. A push into an empty FIFO gives o_valid=1 starting the next cycle (total latency ALU_LAT+1 from i_issue).
  - o_data = mem[rd_ptr] when o_valid, else 0.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - o_count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full: both proceed; count stays at DEPTH and no overflow.
  - When empty: pop cannot occur because o_valid=0; the push proceeds.
- Overflow:
  - A push while full without a pop drops the data, leaves count and pointers unchanged, and sets o_ovf.
  - o_ovf stays set until i_clr_ovf or reset. If set and clear happen in the same cycle, set wins.
- Credit:
  - inflight = number of set bits in the valid pipe.
  - o_issue_ok = (o_count + inflight) < DEPTH, combinational from registered state.
  - The calculation ignores a same-cycle pop, so it is conservative.
  - An issuer honouring o_issue_ok can never cause o_ovf.
- i_issue while o_issue_ok=0 is still tracked; it may cause overflow, which is detected by o_ovf.
- o_data holds stable while o_valid=1 and i_ready=0.

Decomposition:
- Shared package alu_pkg:
  - DATA_W and ALU_LAT constants.
  - Op-select encoding constants: ADD=2'b00, MAX=2'b01, SUB=2'b10, MIN=2'b11.
- One sub-module, alu_lat_pipe:
  - Parameterised ALU_LAT-deep valid shift register with async active-low reset.
  - Outputs the tail bit and the popcount (inflight).
- FIFO storage, pointers, count and flags are in alu_result_buffer.

Test Plan:
1. Single op: ALU ADD 8'h12+8'h34, i_issue pulse at cycle 0, i_ready=1.
   - Required: o_valid=1 at cycle 3 with o_data=8'h46, then o_valid=0 at cycle 4.
   - o_count goes 0→1→0.
2. Fill and backpressure: i_ready=0, issue 4 back-to-back ops (SUB 8'h10-8'h01, MAX 8'h05/8'h09, MIN 8'h05/8'h09, ADD 8'hFF+8'h01).
   - Required: o_issue_ok=0 after the 4th issue; o_full=1 at cycle 6; o_ovf=0.
   - Then i_ready=1: outputs 8'h0F, 8'h09, 8'h05, 8'h00 in order.
3. Overflow: with the FIFO full and i_ready=0, force i_issue while o_issue_ok=0.
   - Required: o_ovf=1 two cycles later; o_count stays 4; the head still reads 8'h0F.
   - i_clr_ovf clears o_ovf the next cycle.
4. Full push+pop: FIFO full, i_ready=1 on the same cycle a result arrives.
   - Required: o_count stays 4; o_ovf=0; the new result appears 4 pops later.
5. Wrap-around: stream 12 ops with i_ready toggling 1/0 every cycle.
   - Required: all 12 results appear in issue order, with no loss or duplication across pointer wrap.
6. Reset mid-flight: issue 2 ops, then pulse i_reset low for 1 cycle before either result is valid.
   - Required: o_valid stays 0, o_count=0, o_issue_ok=1.
   - No stale push after release.
